// File: rtl/fsum_acc_pkg.sv
// Shared definitions for the fsum_acc partial-sum accumulator.
// Holds the FSM encoding, default geometry and the ReLU helper.
package fsum_acc_pkg;

    localparam int MAX_O_SIDE = 128;
    localparam int BURST_LEN  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ADD  = 2'd2,
        ST_WB   = 2'd3
    } state_t;

    // True when ReLU forces the result to +0. Negative zero counts as negative.
    function automatic logic relu_zero(input logic sign_bit, input logic relu_en);
        return sign_bit & relu_en;
    endfunction

endpackage

// File: rtl/fsum_acc_fp_add.sv
// IEEE binary floating-point adder (round-to-nearest-even) with fixed ADD_LAT pipeline.
// One result per operation_nd, rdy exactly ADD_LAT cycles later; no backpressure, rst flushes in-flight ops.
module fp_add #(
    parameter int DW      = 16,
    parameter int ADD_LAT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic          operation_nd,
    output logic [DW-1:0] result,
    output logic          rdy
);

    localparam int EW = (DW == 64) ? 11 : (DW == 32) ? 8 : 5;
    localparam int MW = DW - 1 - EW;
    localparam int FW = MW + 5;
    localparam logic [EW-1:0] EMAX = '1;

    logic [DW-1:0] big, sml, sum_d;
    logic [EW-1:0] be, se, diff;
    logic [FW-1:0] bm, sm, acc;
    logic [EW+1:0] ex;
    logic [MW+1:0] mr;
    logic          sticky;

    always_comb begin
        big = a;
        sml = b;
        if (a[DW-2:0] < b[DW-2:0]) begin
            big = b;
            sml = a;
        end
        be   = (big[DW-2:MW] == '0) ? EW'(1) : big[DW-2:MW];
        se   = (sml[DW-2:MW] == '0) ? EW'(1) : sml[DW-2:MW];
        diff = be - se;
        bm   = {1'b0, big[DW-2:MW] != '0, big[MW-1:0], 3'b000};
        sm   = {1'b0, sml[DW-2:MW] != '0, sml[MW-1:0], 3'b000};
        sticky = 1'b0;
        for (int i = 0; i < FW; i++) begin
            if (i < int'(diff)) sticky = sticky | sm[i];
        end
        sm    = (int'(diff) >= FW) ? '0 : (sm >> diff);
        sm[0] = sm[0] | sticky;
        acc   = (big[DW-1] == sml[DW-1]) ? (bm + sm) : (bm - sm);
        ex    = {2'b00, be};
        if (acc[FW-1]) begin
            acc = {1'b0, acc[FW-1:2], acc[1] | acc[0]};
            ex  = ex + (EW+2)'(1);
        end
        // Left-normalise after cancellation, stopping at the subnormal floor.
        for (int i = 0; i < FW; i++) begin
            if (!acc[FW-2] && ex > (EW+2)'(1)) begin
                acc = acc << 1;
                ex  = ex - (EW+2)'(1);
            end
        end
        if (!acc[FW-2]) ex = '0;
        mr = {1'b0, acc[FW-2:3]} + {{(MW+1){1'b0}}, acc[2] & (acc[1] | acc[0] | acc[3])};
        if (mr[MW+1]) begin
            ex = ex + (EW+2)'(1);
            mr = mr >> 1;
        end else if (ex == '0 && mr[MW]) begin
            ex = (EW+2)'(1);
        end

        if (acc == '0)
            sum_d = {big[DW-1] & sml[DW-1], {(DW-1){1'b0}}};
        else if (ex >= {2'b00, EMAX})
            sum_d = {big[DW-1], EMAX, {MW{1'b0}}};
        else
            sum_d = {big[DW-1], ex[EW-1:0], mr[MW-1:0]};

        if (a[DW-2:MW] == EMAX || b[DW-2:MW] == EMAX) begin
            if (a[DW-2:0] == {EMAX, {MW{1'b0}}} && b[DW-2:0] == {EMAX, {MW{1'b0}}}
                && a[DW-1] != b[DW-1])
                sum_d = {1'b0, EMAX, 1'b1, {(MW-1){1'b0}}};
            else
                sum_d = big;
        end
    end

    logic [DW-1:0]      pipe_q [ADD_LAT];
    logic [DW-1:0]      pipe_d [ADD_LAT];
    logic [ADD_LAT-1:0] vld_q, vld_d;

    always_comb begin
        vld_d[0]  = operation_nd;
        pipe_d[0] = sum_d;
        for (int i = 1; i < ADD_LAT; i++) begin
            vld_d[i]  = vld_q[i-1];
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) vld_q <= '0;
        else     vld_q <= vld_d;
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < ADD_LAT; i++) pipe_q[i] <= pipe_d[i];
    end

    assign result = pipe_q[ADD_LAT-1];
    assign rdy    = vld_q[ADD_LAT-1];

endmodule

// File: rtl/fsum_acc.sv
// Accumulates a LANES-word burst into a partial-sum entry, emitting the final (optionally ReLU'd) sum.
// Burst takes 2+LANES*ADD_LAT cycles from valid to ready; upstream is paced by reads_en, no other backpressure.
module fsum_acc
    import fsum_acc_pkg::*;
#(
    parameter int DW      = 16,
    parameter int LANES   = BURST_LEN,
    parameter int DEPTH   = MAX_O_SIDE,
    parameter int ADD_LAT = 4,
    parameter int IW      = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                fsum_enable,
    output logic                reads_en,
    input  logic                valid,
    input  logic [LANES*DW-1:0] data,
    input  logic [DW-1:0]       bias,
    input  logic [15:0]         i_channel_count,
    input  logic                last_channel,
    input  logic [IW-1:0]       fsum_index,
    input  logic                relu_en,
    output logic [DW-1:0]       fsum_result,
    output logic                result_valid,
    output logic                ready,
    output logic                idx_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(LANES + 1);
    localparam logic [LW-1:0] LANES_W = LW'(LANES);
    localparam logic [IW:0]   DEPTH_W = (IW+1)'(DEPTH);

    logic [DW-1:0] psum_q [DEPTH];

    state_t              state_q, state_d;
    logic [LANES*DW-1:0] data_q, data_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic                last_q, last_d, relu_q, relu_d, bad_q, bad_d, first_q, first_d;
    logic [DW-1:0]       acc_q, acc_d;
    logic [LW-1:0]       lane_q, lane_d;
    logic                reads_en_q, reads_en_d, ready_q, ready_d;
    logic                result_valid_q, result_valid_d, idx_err_q, idx_err_d;
    logic [DW-1:0]       fsum_result_q, fsum_result_d;

    logic          add_nd, add_rdy;
    logic [DW-1:0] add_a, add_b, add_res;
    logic [LW-1:0] lane_sel, lane_nxt;
    logic          idx_ok;
    logic [DW-1:0] psum_rd;

    assign idx_ok   = {1'b0, fsum_index} < DEPTH_W;
    assign psum_rd  = idx_ok ? psum_q[fsum_index[AW-1:0]] : '0;
    assign lane_nxt = lane_q + LW'(1);
    assign add_b    = data_q[lane_sel*DW +: DW];

    always_comb begin
        state_d        = state_q;
        data_d         = data_q;
        idx_d          = idx_q;
        last_d         = last_q;
        relu_d         = relu_q;
        bad_d          = bad_q;
        first_d        = 1'b0;
        acc_d          = acc_q;
        lane_d         = lane_q;
        reads_en_d     = 1'b0;
        ready_d        = 1'b0;
        result_valid_d = 1'b0;
        idx_err_d      = 1'b0;
        fsum_result_d  = fsum_result_q;
        add_nd         = 1'b0;
        add_a          = acc_q;
        lane_sel       = '0;
        case (state_q)
            ST_IDLE: begin
                if (fsum_enable) begin
                    state_d    = ST_REQ;
                    reads_en_d = 1'b1;
                end
            end
            ST_REQ: begin
                if (valid) begin
                    data_d    = data;
                    idx_d     = fsum_index;
                    last_d    = last_channel;
                    relu_d    = relu_en;
                    bad_d     = !idx_ok;
                    idx_err_d = !idx_ok;
                    acc_d     = (i_channel_count == 16'd0) ? bias : psum_rd;
                    lane_d    = '0;
                    first_d   = 1'b1;
                    state_d   = ST_ADD;
                end else begin
                    reads_en_d = 1'b1;
                end
            end
            ST_ADD: begin
                if (first_q) add_nd = 1'b1;
                // Each result chains straight into the next lane so lanes issue every ADD_LAT cycles.
                if (add_rdy) begin
                    acc_d  = add_res;
                    lane_d = lane_nxt;
                    if (lane_nxt < LANES_W) begin
                        add_nd   = 1'b1;
                        add_a    = add_res;
                        lane_sel = lane_nxt;
                    end else begin
                        state_d = ST_WB;
                        ready_d = 1'b1;
                        if (last_q) begin
                            result_valid_d = 1'b1;
                            fsum_result_d  = relu_zero(add_res[DW-1], relu_q) ? '0 : add_res;
                        end
                    end
                end
            end
            ST_WB:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            data_q         <= '0;
            idx_q          <= '0;
            last_q         <= 1'b0;
            relu_q         <= 1'b0;
            bad_q          <= 1'b0;
            first_q        <= 1'b0;
            acc_q          <= '0;
            lane_q         <= '0;
            reads_en_q     <= 1'b0;
            ready_q        <= 1'b0;
            result_valid_q <= 1'b0;
            idx_err_q      <= 1'b0;
            fsum_result_q  <= '0;
        end else begin
            state_q        <= state_d;
            data_q         <= data_d;
            idx_q          <= idx_d;
            last_q         <= last_d;
            relu_q         <= relu_d;
            bad_q          <= bad_d;
            first_q        <= first_d;
            acc_q          <= acc_d;
            lane_q         <= lane_d;
            reads_en_q     <= reads_en_d;
            ready_q        <= ready_d;
            result_valid_q <= result_valid_d;
            idx_err_q      <= idx_err_d;
            fsum_result_q  <= fsum_result_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && state_q == ST_WB && !bad_q) psum_q[idx_q[AW-1:0]] <= acc_q;
    end

    fp_add #(.DW(DW), .ADD_LAT(ADD_LAT)) u_fp_add (
        .clk          (clk),
        .rst          (rst),
        .a            (add_a),
        .b            (add_b),
        .operation_nd (add_nd),
        .result       (add_res),
        .rdy          (add_rdy)
    );

    assign reads_en     = reads_en_q;
    assign ready        = ready_q;
    assign result_valid = result_valid_q;
    assign idx_err      = idx_err_q;
    assign fsum_result  = fsum_result_q;

endmodule

// File: tb/tb_fsum_acc.sv
// Directed bench for fsum_acc: expected events are queued by the driver and matched by a monitor.
module tb_fsum_acc;

    localparam int DW = 16, LANES = 8, DEPTH = 128, ADD_LAT = 4, IW = 8;
    localparam int LAT = 2 + LANES * ADD_LAT;

    logic                clk = 1'b0, rst = 1'b1;
    logic                fsum_enable = 1'b0, valid = 1'b0, last_channel = 1'b0, relu_en = 1'b0;
    logic [LANES*DW-1:0] data = '0;
    logic [DW-1:0]       bias = '0;
    logic [15:0]         i_channel_count = '0;
    logic [IW-1:0]       fsum_index = '0;
    logic                reads_en, result_valid, ready, idx_err;
    logic [DW-1:0]       fsum_result;

    fsum_acc #(.DW(DW), .LANES(LANES), .DEPTH(DEPTH), .ADD_LAT(ADD_LAT), .IW(IW)) dut (
        .clk(clk), .rst(rst), .fsum_enable(fsum_enable), .reads_en(reads_en), .valid(valid),
        .data(data), .bias(bias), .i_channel_count(i_channel_count), .last_channel(last_channel),
        .fsum_index(fsum_index), .relu_en(relu_en), .fsum_result(fsum_result),
        .result_valid(result_valid), .ready(ready), .idx_err(idx_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          kind;   // 0 ready, 1 result, 2 idx_err
        logic [15:0] val;
        int          cyc;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic mon_event(input int kind, input string name);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: unexpected pulse at cycle %0d (value %h)", name, cyc, fsum_result);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.cyc != cyc || (kind == 1 && fsum_result !== e.val)) begin
                errors++;
                $display("FAIL %s: got kind %0d cycle %0d value %h, expected kind %0d cycle %0d value %h",
                         name, kind, cyc, fsum_result, e.kind, e.cyc, e.val);
            end
        end
    endtask

    function automatic logic [LANES*DW-1:0] fill(input logic [DW-1:0] v);
        return {LANES{v}};
    endfunction

    // mode: 0 normal, 1 hold fsum_enable and inject stray valid, 2 abort with reset mid-ADD
    task automatic burst(input logic [LANES*DW-1:0] d, input logic [15:0] b, input logic [15:0] ch,
                         input bit last, input int idx, input bit relu, input logic [15:0] res,
                         input int mode);
        int v, k;
        @(negedge clk);
        fsum_enable = 1'b1;
        @(negedge clk);
        if (mode != 1) fsum_enable = 1'b0;
        k = 0;
        while (!reads_en && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("reads_en_wait", 32'(reads_en), 32'd1);
        data = d; bias = b; i_channel_count = ch; last_channel = last;
        fsum_index = IW'(idx); relu_en = relu; valid = 1'b1;
        v = cyc;
        if (idx >= DEPTH) exp_q.push_back('{kind: 2, val: 16'h0, cyc: v + 1});
        if (mode != 2) begin
            if (last) exp_q.push_back('{kind: 1, val: res, cyc: v + LAT});
            exp_q.push_back('{kind: 0, val: 16'h0, cyc: v + LAT});
        end
        @(negedge clk);
        valid = 1'b0;
        chk("reads_en_after_valid", 32'(reads_en), 32'd0);
        if (mode == 1) begin
            repeat (3) @(negedge clk);
            valid = 1'b1;
            repeat (3) begin
                @(negedge clk);
                chk("reads_en_in_add", 32'(reads_en), 32'd0);
            end
            valid = 1'b0;
            repeat (4) @(negedge clk);
            fsum_enable = 1'b0;
        end
        if (mode == 2) begin
            repeat (10) @(negedge clk);
            rst = 1'b1;
            repeat (2) @(negedge clk);
            chk("rst_reads_en", 32'(reads_en), 32'd0);
            chk("rst_ready", 32'(ready), 32'd0);
            chk("rst_result_valid", 32'(result_valid), 32'd0);
            chk("rst_idx_err", 32'(idx_err), 32'd0);
            chk("rst_fsum_result", 32'(fsum_result), 32'd0);
            rst = 1'b0;
            repeat (LAT + 6) @(negedge clk);
        end
        k = 0;
        while (exp_q.size() != 0 && k < LAT + 20) begin
            @(negedge clk);
            k++;
        end
        chk("drain", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        @(negedge clk);
    endtask

    initial begin
        logic [LANES*DW-1:0] dv;
        fork
            forever begin
                @(negedge clk);
                if (!rst) begin
                    if (idx_err)      mon_event(2, "idx_err");
                    if (result_valid) mon_event(1, "result");
                    if (ready)        mon_event(0, "ready");
                end
            end
        join_none

        repeat (3) @(negedge clk);
        chk("reset_reads_en", 32'(reads_en), 32'd0);
        chk("reset_ready", 32'(ready), 32'd0);
        chk("reset_result_valid", 32'(result_valid), 32'd0);
        chk("reset_idx_err", 32'(idx_err), 32'd0);
        chk("reset_fsum_result", 32'(fsum_result), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 0.5 + 8 * 1.0 = 8.5
        burst(fill(16'h3C00), 16'h3800, 16'd0, 1'b1, 5, 1'b0, 16'h4840, 0);
        // Two channels into the same entry: 8.5 then 8.5 + 8 = 16.5
        burst(fill(16'h3C00), 16'h3800, 16'd0, 1'b0, 5, 1'b0, 16'h0000, 0);
        chk("result_hold", 32'(fsum_result), 32'h4840);
        burst(fill(16'h3C00), 16'h0000, 16'd1, 1'b1, 5, 1'b0, 16'h4C20, 0);
        // -8 + 8 * -1 = -16, with and without ReLU
        burst(fill(16'hBC00), 16'hC800, 16'd0, 1'b1, 7, 1'b0, 16'hCC00, 0);
        burst(fill(16'hBC00), 16'hC800, 16'd0, 1'b1, 7, 1'b1, 16'h0000, 0);
        // Negative zero sums stay -0; ReLU maps it to +0
        burst(fill(16'h8000), 16'h8000, 16'd0, 1'b1, 8, 1'b0, 16'h8000, 0);
        burst(fill(16'h8000), 16'h8000, 16'd0, 1'b1, 8, 1'b1, 16'h0000, 0);
        // Lanes 1..8 = 36.0
        dv = {16'h4800, 16'h4700, 16'h4600, 16'h4500, 16'h4400, 16'h4200, 16'h4000, 16'h3C00};
        burst(dv, 16'h0000, 16'd0, 1'b1, 10, 1'b0, 16'h5080, 0);
        // Aborted burst, then 2.0 + 8 * 1.0 = 10.0
        burst(fill(16'h3C00), 16'h3800, 16'd0, 1'b1, 9, 1'b0, 16'h0000, 2);
        burst(fill(16'h3C00), 16'h4000, 16'd0, 1'b1, 9, 1'b0, 16'h4900, 0);
        // Out-of-range index reads 0 and must not alias onto entry 200 mod 128 = 72
        burst(fill(16'h0000), 16'h3C00, 16'd0, 1'b0, 72, 1'b0, 16'h0000, 0);
        burst(fill(16'h3C00), 16'h0000, 16'd1, 1'b1, 200, 1'b0, 16'h4800, 0);
        burst(fill(16'h0000), 16'h0000, 16'd1, 1'b1, 72, 1'b0, 16'h3C00, 0);
        // Stray valid while idle, then a burst with fsum_enable held and stray valid mid-ADD
        valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("reads_en_idle_valid", 32'(reads_en), 32'd0);
        end
        valid = 1'b0;
        burst(fill(16'h3C00), 16'h3800, 16'd0, 1'b1, 3, 1'b0, 16'h4840, 1);
        repeat (20) begin
            @(negedge clk);
            chk("reads_en_quiet", 32'(reads_en), 32'd0);
        end
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fsum_acc.md
FSUM_ACC -- requirements
Module: fsum_acc

Interface
REQ-001 Parameter DW, default 16, operand/result width (IEEE fp16 at default).
REQ-002 Parameter LANES, default 8, data words per burst.
REQ-003 Parameter DEPTH, default 128, partial-sum entries (output positions).
REQ-004 Parameter ADD_LAT, default 4, fixed latency of the adder sub-module, range 1..15.
REQ-005 Parameter IW, default 8, index width, with 2**IW >= DEPTH.
REQ-006 clk  in  1  sole clock; all logic on rising edge.
REQ-007 rst  in  1  reset, synchronous and active-high.
REQ-008 fsum_enable  in  1  start pulse; sampled only in IDLE.
REQ-009 reads_en  out  1  burst read request to the upstream buffer.
REQ-010 valid  in  1  data/bias qualifier; sampled only in REQ.
REQ-011 data  in  LANES*DW  burst; lane k = data[DW*k +: DW].
REQ-012 bias  in  DW  initial value, used when i_channel_count==0.
REQ-013 i_channel_count  in  16  current input channel.
REQ-014 last_channel  in  1  final channel; result is emitted.
REQ-015 fsum_index  in  IW  partial-sum entry for this burst.
REQ-016 relu_en  in  1  apply ReLU to the emitted result.
REQ-017 fsum_result  out  DW  final sum, valid with result_valid.
REQ-018 result_valid  out  1  one-cycle pulse.
REQ-019 ready  out  1  one-cycle pulse at the end of every burst.
REQ-020 idx_err  out  1  one-cycle pulse when fsum_index >= DEPTH.

Function
REQ-021 FSM states: IDLE, REQ, ADD, WB; a single state register.
REQ-022 IDLE -> REQ on fsum_enable; reads_en is high in every REQ cycle and low otherwise.
REQ-023 On valid in REQ, latch data, fsum_index, last_channel and relu_en; set acc to bias if i_channel_count==0, else to psum[fsum_index]; set lane=0; go to ADD.
REQ-024 In ADD, issue acc + lane[lane] to the adder with a one-cycle nd on the first ADD cycle and on each rdy cycle while lane < LANES.
REQ-025 On each rdy, acc takes the adder result and lane increments; if lane reaches LANES, go to WB.
REQ-026 Timing: with t0 = the cycle after valid, lane k issues at t0+k*ADD_LAT and the final rdy arrives at t0+LANES*ADD_LAT.
REQ-027 WB, one cycle: write acc to psum[index] and pulse ready.
REQ-028 In WB, if last_channel was latched, also drive fsum_result (0 if relu_en and sign bit set, else acc) and pulse result_valid.
REQ-029 WB -> IDLE; fsum_result holds its value until the next result_valid.
REQ-030 fsum_enable outside IDLE is ignored.
REQ-031 valid outside REQ is ignored.
REQ-032 If fsum_index >= DEPTH at valid, pulse idx_err, read 0 instead of psum, and suppress the psum write; the burst otherwise completes normally.
REQ-033 ReLU of negative zero (sign set, all other bits 0) yields 0.

Reset
REQ-034 rst returns the FSM to IDLE from any state, dropping any in-flight burst; adder results arriving after reset are discarded.
REQ-035 Outputs after reset: reads_en=0, ready=0, result_valid=0, idx_err=0, fsum_result=0.
REQ-036 psum storage is not cleared by reset; a burst with i_channel_count==0 redefines its entry.

Structure
REQ-037 State encodings and the ReLU helper live in the shared macros/package header alongside MAX_O_SIDE and BURST_LEN.
REQ-038 DEPTH and LANES default to MAX_O_SIDE and BURST_LEN.
REQ-039 Exactly one sub-module, fp_add (DW-bit adder: a, b, operation_nd, result, rdy; latency ADD_LAT), instantiated once.
REQ-040 psum is a DEPTH x DW synchronous-write register array.

Verification (LANES=8, ADD_LAT=4)
REQ-041 Bias 0x3800, all lanes 0x3C00, channel 0, last, index 5 -> fsum_result 0x4840; result_valid exactly 34 cycles after valid.
REQ-042 Two bursts at index 5: channel 0 not last, then channel 1 last, all lanes 0x3C00 -> ready after the first only; result 0x4C20.
REQ-043 Bias 0xC800, lanes 0xBC00, channel 0, last: relu_en=0 -> 0xCC00; relu_en=1 -> 0x0000.
REQ-044 rst asserted mid-ADD, then a fresh burst -> no ready/result from the aborted burst; the new burst's result is correct.
REQ-045 fsum_index=200 -> idx_err pulse, psum unchanged, ready still pulses.
REQ-046 fsum_enable held during a burst plus a stray valid in IDLE -> no extra bursts; reads_en low outside REQ.
